// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_bht
// Purpose  : Direct-mapped branch history table + branch target buffer.
//            Fetch side gets a same-cycle prediction for PCF. Execute side
//            trains the table from resolved branches/jumps and flags
//            mispredicts with the redirect address.
// Options  : `define BP_STATS_EN adds BranchCount/MispredCount/HitCount.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [XLEN-1:0] PCE,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
`ifdef BP_STATS_EN
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount,
  output logic [31:0]     HitCount,
`endif
  output logic [XLEN-1:0] CorrectPCE
);

  localparam int              ENTRIES = 1 << INDEX_BITS;
  localparam int              TAG_W   = XLEN - INDEX_BITS - 2;
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);

  // Table storage: one entry per index.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic                  resolve_e;

  logic            upd_en_d;
  logic [1:0]      upd_ctr_d;
  logic [XLEN-1:0] upd_target_d;

  assign idx_f     = PCF[INDEX_BITS+1:2];
  assign tag_f     = PCF[XLEN-1:INDEX_BITS+2];
  assign idx_e     = PCE[INDEX_BITS+1:2];
  assign tag_e     = PCE[XLEN-1:INDEX_BITS+2];
  assign resolve_e = BranchE | JumpE;

  // Fetch lookup reads registered state only, so a same-cycle update is not
  // bypassed; reset clears valid immediately, forcing a miss.
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign PredTakenF  = hit_f & ctr_q[idx_f][1];
  assign PredTargetF = hit_f ? target_q[idx_f] : (PCF + PC_INC);

  assign MispredictE = resolve_e &
                       ((PCSrcE != PredTakenE) |
                        (PCSrcE & PredTakenE & (PredTargetE != PCTargetE)));
  assign CorrectPCE  = PCSrcE ? PCTargetE : (PCE + PC_INC);

  // Compute the new contents of the execute-side entry; JumpE beats BranchE.
  always_comb begin
    upd_en_d     = 1'b0;
    upd_ctr_d    = ctr_q[idx_e];
    upd_target_d = target_q[idx_e];
    if (resolve_e) begin
      if (hit_e) begin
        upd_en_d = 1'b1;
        if (JumpE)
          upd_ctr_d = 2'd3;
        else if (PCSrcE)
          upd_ctr_d = (ctr_q[idx_e] == 2'd3) ? 2'd3 : ctr_q[idx_e] + 2'd1;
        else
          upd_ctr_d = (ctr_q[idx_e] == 2'd0) ? 2'd0 : ctr_q[idx_e] - 2'd1;
        if (PCSrcE)
          upd_target_d = PCTargetE;
      end else if (PCSrcE) begin
        // Allocation overwrites whatever occupies this index.
        upd_en_d     = 1'b1;
        upd_ctr_d    = JumpE ? 2'd3 : 2'd2;
        upd_target_d = PCTargetE;
      end
    end
  end

  // Table write: reset clears every entry to weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
    end else if (upd_en_d) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= upd_target_d;
      ctr_q[idx_e]    <= upd_ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q, hit_cnt_q;

  // Free-running event counters, wrapping at 2**32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      hit_cnt_q     <= '0;
    end else begin
      if (resolve_e)   branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (MispredictE) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      if (hit_f)       hit_cnt_q     <= hit_cnt_q + 32'd1;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
  assign HitCount     = hit_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_bht
// Purpose  : Directed self-checking bench for branch_predictor_bht.
//            Honours `define BP_STATS_EN for the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, PCTargetE, PredTargetE;
  logic        BranchE, JumpE, PCSrcE, PredTakenE;
  logic        PredTakenF, MispredictE;
  logic [31:0] PredTargetF, CorrectPCE;
`ifdef BP_STATS_EN
  logic [31:0] BranchCount, MispredCount, HitCount;
`endif

  int n_vec = 0;
  int n_err = 0;

  branch_predictor_bht #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .PCE         (PCE),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .MispredictE (MispredictE),
`ifdef BP_STATS_EN
    .BranchCount (BranchCount),
    .MispredCount(MispredCount),
    .HitCount    (HitCount),
`endif
    .CorrectPCE  (CorrectPCE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a resolving instruction on the execute side.
  task automatic resolve(input logic br, input logic jp, input logic [31:0] pce,
                         input logic src, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    BranchE = br; JumpE = jp; PCE = pce; PCSrcE = src;
    PCTargetE = tgt; PredTakenE = pt; PredTargetE = ptgt;
    #1;
  endtask

  // Take one clock edge, then drop the resolve strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    BranchE = 1'b0; JumpE = 1'b0;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic taken, input logic [31:0] tgt);
    PCF = pc;
    #1;
    check({tag, ".taken"},  {31'd0, PredTakenF}, {31'd0, taken});
    check({tag, ".target"}, PredTargetF, tgt);
  endtask

  initial begin
    rst = 1'b1; PCF = '0; PCE = '0; PCTargetE = '0; PredTargetE = '0;
    BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b0; PredTakenE = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state and an untaken resolve on a miss: no allocation.
    lookup("rst_0x100", 32'h100, 1'b0, 32'h104);
    resolve(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    check("nt_mis", {31'd0, MispredictE}, 32'd0);
    check("nt_cpc", CorrectPCE, 32'h104);
    tick();
    lookup("nt_noalloc", 32'h100, 1'b0, 32'h104);

    // Taken branch on a miss: mispredict, allocate weakly taken.
    resolve(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    check("tk_mis", {31'd0, MispredictE}, 32'd1);
    check("tk_cpc", CorrectPCE, 32'h80);
    tick();
    lookup("alloc", 32'h100, 1'b1, 32'h80);
    lookup("idx1_miss", 32'h104, 1'b0, 32'h108);

    // Counter training: 2->3->3, then down 3->2->1->0, then up to 1.
    resolve(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    check("tk_hit_ok", {31'd0, MispredictE}, 32'd0);
    tick();
    resolve(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80); tick();
    resolve(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80); tick();
    lookup("ctr2", 32'h100, 1'b1, 32'h80);
    resolve(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt_pt_mis", {31'd0, MispredictE}, 32'd1);
    check("nt_pt_cpc", CorrectPCE, 32'h104);
    tick();
    lookup("ctr1", 32'h100, 1'b0, 32'h80);
    resolve(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104); tick();
    resolve(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104); tick();
    resolve(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104); tick();
    lookup("sat_lo", 32'h100, 1'b0, 32'h80);

    // Alias at 0x200 (same index, different tag) evicts 0x100.
    resolve(1'b1, 1'b0, 32'h200, 1'b1, 32'h280, 1'b0, 32'h204); tick();
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    lookup("alias_new", 32'h200, 1'b1, 32'h280);
    resolve(1'b1, 1'b0, 32'h200, 1'b1, 32'h2C0, 1'b1, 32'h280);
    check("tgt_mis", {31'd0, MispredictE}, 32'd1);
    tick();
    lookup("tgt_upd", 32'h200, 1'b1, 32'h2C0);

    // No resolve: mispredict held low whatever the other inputs say.
    BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b1; PredTakenE = 1'b0; #1;
    check("no_resolve", {31'd0, MispredictE}, 32'd0);

    // Same-cycle read/write: no bypass.
    PCF = 32'h300;
    resolve(1'b1, 1'b0, 32'h300, 1'b1, 32'h340, 1'b0, 32'h304);
    check("conflict_pre", {31'd0, PredTakenF}, 32'd0);
    tick();
    lookup("conflict_post", 32'h300, 1'b1, 32'h340);

    // Jump with wrong predicted target; jump forces ctr=3.
    resolve(1'b0, 1'b1, 32'h300, 1'b1, 32'h44, 1'b1, 32'h40);
    check("jmp_mis", {31'd0, MispredictE}, 32'd1);
    check("jmp_cpc", CorrectPCE, 32'h44);
    tick();
    resolve(1'b1, 1'b0, 32'h300, 1'b0, 32'h44, 1'b1, 32'h44); tick();
    lookup("jmp_ctr3", 32'h300, 1'b1, 32'h44);

    // Jump allocation on miss with BranchE also high: ctr=3 survives one not-taken.
    resolve(1'b1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404); tick();
    resolve(1'b1, 1'b0, 32'h400, 1'b0, 32'h500, 1'b1, 32'h500); tick();
    lookup("jalloc", 32'h400, 1'b1, 32'h500);

    // Wrap of PC+4.
    lookup("wrap_f", 32'hFFFF_FFFC, 1'b0, 32'h0);
    PCE = 32'hFFFF_FFFC; PCSrcE = 1'b0; #1;
    check("wrap_e", CorrectPCE, 32'h0);

    // Reset asserted mid-operation with an update pending.
    @(negedge clk);
    PCF = 32'h400;
    resolve(1'b1, 1'b0, 32'h600, 1'b1, 32'h700, 1'b0, 32'h604);
    rst = 1'b1; #1;
    lookup("rst_async", 32'h400, 1'b0, 32'h404);
    check("rst_mis", {31'd0, MispredictE}, 32'd1);
    @(posedge clk); #1;
    BranchE = 1'b0; rst = 1'b0; #1;
    lookup("rst_discard", 32'h600, 1'b0, 32'h604);

    // Four resolves, two mispredicts, from a clean reset.
    resolve(1'b1, 1'b0, 32'h600, 1'b0, 32'h700, 1'b0, 32'h604); tick();
    resolve(1'b1, 1'b0, 32'h600, 1'b1, 32'h700, 1'b0, 32'h604); tick();
    resolve(1'b1, 1'b0, 32'h600, 1'b1, 32'h700, 1'b1, 32'h700); tick();
    resolve(1'b1, 1'b0, 32'h600, 1'b0, 32'h700, 1'b1, 32'h700);
    check("final_mis", {31'd0, MispredictE}, 32'd1);
    tick();
`ifdef BP_STATS_EN
    check("BranchCount",  BranchCount,  32'd4);
    check("MispredCount", MispredCount, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
